// File: rtl/key_search_pkg.sv
// Shared types and defaults for the multi-core RC4 key search scheduler.
package key_search_pkg;

    localparam int                    KS_KEY_W   = 24;
    localparam logic [KS_KEY_W-1:0]   KS_KEY_MAX = 24'h3FFFFF;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_RUN            = 3'd1,
        ST_DRAIN          = 3'd2,
        ST_DONE_FOUND     = 3'd3,
        ST_DONE_EXHAUSTED = 3'd4
    } state_t;

    // Why the scheduler is draining: a winning key, or an operator abort.
    localparam logic DRAIN_FOUND = 1'b0;
    localparam logic DRAIN_ABORT = 1'b1;

endpackage

// File: rtl/rr_idle_picker.sv
// Combinational round-robin finder: first idle core at or after ptr, wrapping.
module rr_idle_picker #(
    parameter int NUM_CORES = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_CORES-1:0] idle,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic                 any_idle
);

    logic [PTR_W-1:0] idx;
    logic             taken;

    // Walk the cores starting at ptr and grant the first idle one.
    always_comb begin
        grant = '0;
        taken = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_CORES);
            if (!taken && idle[idx]) begin
                grant[idx] = 1'b1;
                taken      = 1'b1;
            end
        end
    end

    assign any_idle = |idle;

endmodule

// File: rtl/key_search_scheduler.sv
// Hands consecutive candidate keys to idle cracking cores round-robin and
// collects their results; stops on the first valid key or range exhaustion.
//
// Core handshake: the scheduler pulses core_start[i] for one cycle with
// core_key slice i, and holds that slice until the matching core_ack. The core
// raises core_done[i] (with core_valid[i] qualified by it) and holds it until
// it sees core_ack[i], which the scheduler pulses for exactly one cycle on the
// cycle after it samples done from a core it considers busy.
module key_search_scheduler
    import key_search_pkg::*;
#(
    parameter int               NUM_CORES = 4,
    parameter int               KEY_W     = KS_KEY_W,
    parameter logic [KEY_W-1:0] KEY_MAX   = KEY_W'(KS_KEY_MAX)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic [NUM_CORES-1:0]       core_start,
    output logic [NUM_CORES*KEY_W-1:0] core_key,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_valid,
    output logic [NUM_CORES-1:0]       core_ack,
    output logic                       busy,
    output logic                       found,
    output logic                       not_found,
    output logic [KEY_W-1:0]           found_key,
    output logic [KEY_W:0]             keys_tried,
    output logic [2:0]                 state
);

    localparam int               PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [KEY_W:0]   LAST_KEY = {1'b0, KEY_MAX};
    localparam logic [KEY_W:0]   ONE_K    = {{KEY_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CORES - 1);
    localparam logic [PTR_W-1:0] ONE_P    = {{(PTR_W-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic                  drain_reason;
    logic [KEY_W:0]        next_key;
    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_CORES-1:0]  core_busy;

    logic [NUM_CORES-1:0]  idle;
    logic [NUM_CORES-1:0]  grant;
    logic [NUM_CORES-1:0]  hits;
    logic [NUM_CORES-1:0]  valid_hits;
    logic                  any_idle;
    logic                  keys_left;
    logic                  do_dispatch;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      ptr_after;
    logic [KEY_W:0]        hit_count;
    logic [KEY_W-1:0]      min_key;

    // A core being acked this cycle is not offered again until the next one.
    assign idle       = ~core_busy & ~core_ack;
    assign hits       = core_done & core_busy;
    assign valid_hits = hits & core_valid;
    assign keys_left  = (next_key <= LAST_KEY);
    assign state      = state_q;

    assign do_dispatch = (state_q == ST_RUN) && !abort && (valid_hits == '0)
                         && keys_left && any_idle;

    rr_idle_picker #(
        .NUM_CORES (NUM_CORES),
        .PTR_W     (PTR_W)
    ) u_picker (
        .idle     (idle),
        .ptr      (rr_ptr),
        .grant    (grant),
        .any_idle (any_idle)
    );

    // Grant index, completion count and smallest winning key this cycle.
    always_comb begin
        grant_idx = '0;
        hit_count = '0;
        min_key   = '1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
            if (hits[i]) hit_count = hit_count + ONE_K;
            if (valid_hits[i] && (core_key[i*KEY_W +: KEY_W] < min_key))
                min_key = core_key[i*KEY_W +: KEY_W];
        end
        ptr_after = (grant_idx == LAST_PTR) ? '0 : grant_idx + ONE_P;
    end

    // Scheduler FSM with dispatch, completion bookkeeping and result flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            drain_reason <= DRAIN_FOUND;
            next_key     <= '0;
            rr_ptr       <= '0;
            core_busy    <= '0;
            core_start   <= '0;
            core_key     <= '0;
            core_ack     <= '0;
            busy         <= 1'b0;
            found        <= 1'b0;
            not_found    <= 1'b0;
            found_key    <= '0;
            keys_tried   <= '0;
        end else begin
            core_start <= '0;
            core_ack   <= hits;
            core_busy  <= (core_busy & ~hits) | (do_dispatch ? grant : '0);
            keys_tried <= keys_tried + hit_count;

            if (do_dispatch) begin
                core_start <= grant;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (grant[i]) core_key[i*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
                end
                next_key <= next_key + ONE_K;
                rr_ptr   <= ptr_after;
            end

            case (state_q)
                ST_IDLE, ST_DONE_FOUND, ST_DONE_EXHAUSTED: begin
                    if (start && !abort) begin
                        state_q    <= ST_RUN;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        not_found  <= 1'b0;
                        found_key  <= '0;
                        keys_tried <= '0;
                        next_key   <= '0;
                        rr_ptr     <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q      <= ST_DRAIN;
                        drain_reason <= DRAIN_ABORT;
                    end else if (valid_hits != '0) begin
                        state_q      <= ST_DRAIN;
                        drain_reason <= DRAIN_FOUND;
                        found        <= 1'b1;
                        found_key    <= min_key;
                    end else if (!keys_left && (core_busy == '0)) begin
                        state_q   <= ST_DONE_EXHAUSTED;
                        busy      <= 1'b0;
                        not_found <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (core_busy == '0) begin
                        state_q <= (drain_reason == DRAIN_ABORT) ? ST_IDLE : ST_DONE_FOUND;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: four behavioural cracking cores, directed
// runs, and a dispatch scoreboard fed at start and drained by a monitor.
module tb_key_search_scheduler;

    localparam int            NC   = 4;
    localparam int            KW   = 24;
    localparam logic [KW-1:0] KMAX = 24'd15;
    localparam int            LAT  = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FOUND = 3'd3;
    localparam logic [2:0] S_EXH   = 3'd4;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [NC-1:0]     core_start;
    logic [NC*KW-1:0]  core_key;
    logic [NC-1:0]     core_done;
    logic [NC-1:0]     core_valid;
    logic [NC-1:0]     core_ack;
    logic              busy;
    logic              found;
    logic              not_found;
    logic [KW-1:0]     found_key;
    logic [KW:0]       keys_tried;
    logic [2:0]        state;

    int                checks = 0;
    int                errors = 0;
    logic [KW-1:0]     exp_q[$];
    int                starts_cnt = 0;
    int                acks_cnt   = 0;
    logic              pair_acked = 1'b0;
    logic              sync56     = 1'b0;
    logic [15:0]       valid_mask = 16'h0000;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    key_search_scheduler #(
        .NUM_CORES (NC),
        .KEY_W     (KW),
        .KEY_MAX   (KMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .core_start (core_start),
        .core_key   (core_key),
        .core_done  (core_done),
        .core_valid (core_valid),
        .core_ack   (core_ack),
        .busy       (busy),
        .found      (found),
        .not_found  (not_found),
        .found_key  (found_key),
        .keys_tried (keys_tried),
        .state      (state)
    );

    // ---------------- core models ----------------
    // Each core counts LAT cycles after its start, then holds done until ack.
    // With sync56 set, the cores holding keys 5 and 6 raise done together.
    int            m_cnt[NC];
    logic [KW-1:0] m_key[NC];
    logic [NC-1:0] m_ripe;
    int            ripe56;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_done  <= '0;
            core_valid <= '0;
            m_ripe     <= '0;
            for (int i = 0; i < NC; i++) begin
                m_cnt[i] <= 0;
                m_key[i] <= '0;
            end
        end else begin
            ripe56 = 0;
            for (int i = 0; i < NC; i++)
                if (m_ripe[i] && (m_key[i] == 24'd5 || m_key[i] == 24'd6)) ripe56++;
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    m_key[i]      <= core_key[i*KW +: KW];
                    m_cnt[i]      <= LAT;
                    m_ripe[i]     <= 1'b0;
                    core_done[i]  <= 1'b0;
                    core_valid[i] <= 1'b0;
                end else begin
                    if (m_cnt[i] > 0) begin
                        m_cnt[i] <= m_cnt[i] - 1;
                        if (m_cnt[i] == 1) m_ripe[i] <= 1'b1;
                    end
                    if (m_ripe[i] && !core_done[i] &&
                        (!sync56 || !(m_key[i] == 24'd5 || m_key[i] == 24'd6) || ripe56 == 2)) begin
                        core_done[i]  <= 1'b1;
                        core_valid[i] <= valid_mask[m_key[i][3:0]];
                        m_ripe[i]     <= 1'b0;
                    end
                    if (core_done[i] && core_ack[i]) begin
                        core_done[i]  <= 1'b0;
                        core_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [191:0] got, input logic [191:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    task automatic push_run();
        exp_q.delete();
        for (int k = 0; k <= int'(KMAX); k++) exp_q.push_back(KW'(k));
        starts_cnt = 0;
        acks_cnt   = 0;
        pair_acked = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [KW-1:0] exp_k;
    logic          has5;
    logic          has6;

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            if (core_start != '0) begin
                checks++;
                if ($countones(core_start) != 1 || state != S_RUN || found) begin
                    errors++;
                    $display("FAIL dispatch_ctx start=%b state=%0d found=%b required one-hot start in RUN with found=0",
                             core_start, state, found);
                end
                for (int i = 0; i < NC; i++) begin
                    if (core_start[i]) begin
                        starts_cnt++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL dispatch_key core %0d got key %0d required no dispatch",
                                     i, core_key[i*KW +: KW]);
                        end else begin
                            exp_k = exp_q.pop_front();
                            if (core_key[i*KW +: KW] !== exp_k) begin
                                errors++;
                                $display("FAIL dispatch_key core %0d got key %0d required %0d",
                                         i, core_key[i*KW +: KW], exp_k);
                            end
                        end
                    end
                end
            end
            has5 = 1'b0;
            has6 = 1'b0;
            for (int i = 0; i < NC; i++) begin
                if (core_ack[i]) begin
                    acks_cnt++;
                    checks++;
                    if (!core_done[i]) begin
                        errors++;
                        $display("FAIL spurious_ack core %0d got ack with done=0 required done=1", i);
                    end
                    if (m_key[i] == 24'd5) has5 = 1'b1;
                    if (m_key[i] == 24'd6) has6 = 1'b1;
                end
            end
            if (has5 && has6) pair_acked = 1'b1;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int n_wait;
    int starts_at_abort;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {core_start, core_key, core_ack, busy, found, not_found, found_key, keys_tried, state}, 192'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, state}, {1'b0, S_IDLE});

        // Run 1: only key 9 is valid
        valid_mask = 16'h0200;
        push_run();
        pulse_start();
        wait_idle("t1_drain_timeout");
        check("t1_state", state, S_FOUND);
        check("t1_flags", {found, not_found}, 2'b10);
        check("t1_found_key", found_key, 24'd9);
        check("t1_every_start_acked", acks_cnt, starts_cnt);
        check("t1_keys_tried", keys_tried, starts_cnt);
        check("t1_reached_key9", {31'd0, starts_cnt >= 10}, 32'd1);

        // Restart from DONE_FOUND; keys 5 and 6 valid and finishing together
        valid_mask = 16'h0060;
        sync56     = 1'b1;
        push_run();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        check("t6_cleared_after_e0", {state, found, not_found, found_key, keys_tried},
              {S_RUN, 2'b00, 24'd0, 25'd0});
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
        check("t6_first_dispatch_e1", {core_start, core_key[KW-1:0]}, {4'b0001, 24'd0});
        wait_idle("t2_drain_timeout");
        check("t2_found_key_min", found_key, 24'd5);
        check("t2_flags", {found, not_found}, 2'b10);
        check("t2_pair_acked_same_cycle", {31'd0, pair_acked}, 32'd1);
        check("t2_every_start_acked", acks_cnt, starts_cnt);
        sync56 = 1'b0;

        // Exhaustion, with a start pulse mid-run that must be ignored
        valid_mask = 16'h0000;
        push_run();
        pulse_start();
        repeat (15) @(negedge clk);
        pulse_start();
        wait_idle("t3_run_timeout");
        check("t3_state", state, S_EXH);
        check("t3_flags", {found, not_found}, 2'b01);
        check("t3_keys_tried", keys_tried, 25'd16);
        check("t3_all_keys_dispatched", exp_q.size(), 32'd0);
        check("t3_acks", acks_cnt, 32'd16);
        check("t3_found_key_zero", found_key, 24'd0);
        pulse_abort();
        @(posedge clk);
        #1;
        check("t3_abort_ignored_in_done", {state, not_found}, {S_EXH, 1'b1});

        // Abort 20 cycles into a run
        push_run();
        pulse_start();
        repeat (20) @(negedge clk);
        pulse_abort();
        starts_at_abort = starts_cnt;
        wait_idle("t4_drain_timeout");
        check("t4_state", state, S_IDLE);
        check("t4_flags", {found, not_found}, 2'b00);
        check("t4_no_start_after_abort", starts_cnt, starts_at_abort);
        check("t4_outstanding_acked", acks_cnt, starts_cnt);
        check("t4_stopped_early", {31'd0, exp_q.size() > 0}, 32'd1);

        // Asynchronous reset while three cores are busy
        push_run();
        pulse_start();
        n_wait = 0;
        while (starts_cnt < 3 && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        check("t5_three_started", {31'd0, starts_cnt >= 3}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_reset_outputs",
              {core_start, core_key, core_ack, busy, found, not_found, found_key, keys_tried, state}, 192'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_idle_after_release", {state, busy, core_start}, {S_IDLE, 1'b0, 4'b0000});

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
